// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage.
// Load-type one-hot indices, exception bundle layout, latched bundle.
package mem_stage_pkg;

  localparam int EX_ZIP_W = 81;

  localparam int LD_B  = 4;
  localparam int LD_BU = 3;
  localparam int LD_H  = 2;
  localparam int LD_HU = 1;
  localparam int LD_W  = 0;

  localparam int ZIP_ERTN        = 0;
  localparam int ZIP_SYSCALL     = 1;
  localparam int ZIP_CSR_WE      = 2;
  localparam int ZIP_CSR_NUM_LO  = 3;
  localparam int ZIP_CSR_NUM_HI  = 16;
  localparam int ZIP_CSR_MASK_LO = 17;
  localparam int ZIP_CSR_MASK_HI = 48;
  localparam int ZIP_CSR_WVAL_LO = 49;
  localparam int ZIP_CSR_WVAL_HI = 80;

  typedef struct packed {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] alu_result;
    logic        res_from_mem;
    logic [4:0]  ld_inst;
    logic        csr_re;
  } ms_bundle_t;

  function automatic logic zip_is_ex(
    input logic [EX_ZIP_W-1:0] zip
  );
    return zip[ZIP_SYSCALL] | zip[ZIP_ERTN];
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks byte/halfword by offset and extends it.
// Purely combinational; an all-zero load type returns the full word.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [4:0]  ld_inst,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[{offset, 3'b000} +: 8];
    half_v = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    result = rdata;
    unique case (1'b1)
      ld_inst[LD_B]:  result = {{24{byte_v[7]}}, byte_v};
      ld_inst[LD_BU]: result = {24'd0, byte_v};
      ld_inst[LD_H]:  result = {{16{half_v[15]}}, half_v};
      ld_inst[LD_HU]: result = {16'd0, half_v};
      ld_inst[LD_W]:  result = rdata;
      default:        result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: latches the execute bundle, aligns load data,
// and holds SRAM read data while write-back stalls.
module mem_stage #(
  parameter int EX_ZIP_W = mem_stage_pkg::EX_ZIP_W,
  parameter int ADDR_W   = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                es_to_ms_valid,
  output logic                ms_allowin,
  input  logic [ADDR_W-1:0]   es_pc,
  input  logic                es_rf_we,
  input  logic [4:0]          es_rf_waddr,
  input  logic [ADDR_W-1:0]   es_alu_result,
  input  logic                es_res_from_mem,
  input  logic [4:0]          es_ld_inst,
  input  logic                es_csr_re,
  input  logic [EX_ZIP_W-1:0] es_ex_zip,
  input  logic [ADDR_W-1:0]   data_sram_rdata,
  input  logic                ws_allowin,
  input  logic                wb_ex,
  output logic                ms_to_ws_valid,
  output logic [ADDR_W-1:0]   ms_pc,
  output logic                ms_rf_we,
  output logic [4:0]          ms_rf_waddr,
  output logic [ADDR_W-1:0]   ms_rf_wdata,
  output logic                ms_res_from_mem,
  output logic                ms_csr_re,
  output logic [EX_ZIP_W-1:0] ms_ex_zip,
  output logic                ms_ex
);

  import mem_stage_pkg::*;

  ms_bundle_t          bnd_q, bnd_d;
  logic [EX_ZIP_W-1:0] zip_q, zip_d;
  logic                ms_valid_q, ms_valid_d;
  logic                rbuf_valid_q, rbuf_valid_d;
  logic [31:0]         rbuf_q, rbuf_d;

  logic                ms_ready_go;
  logic                accept;
  logic                hold_capture;
  logic [31:0]         eff_rdata;
  logic [31:0]         ld_data;

  assign ms_ready_go    = 1'b1;
  assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid_q && ms_ready_go;
  assign accept         = es_to_ms_valid && ms_allowin && !wb_ex;

  // SRAM data is only valid in the first resident cycle; keep it if stalled
  assign hold_capture = ms_valid_q && !ws_allowin &&
                        bnd_q.res_from_mem && !rbuf_valid_q;

  always_comb begin
    ms_valid_d = ms_valid_q;
    if (wb_ex) begin
      ms_valid_d = 1'b0;
    end else if (ms_allowin) begin
      ms_valid_d = es_to_ms_valid;
    end
  end

  always_comb begin
    bnd_d = bnd_q;
    zip_d = zip_q;
    if (accept) begin
      bnd_d.pc           = es_pc;
      bnd_d.rf_we        = es_rf_we;
      bnd_d.rf_waddr     = es_rf_waddr;
      bnd_d.alu_result   = es_alu_result;
      bnd_d.res_from_mem = es_res_from_mem;
      bnd_d.ld_inst      = es_ld_inst;
      bnd_d.csr_re       = es_csr_re;
      zip_d              = es_ex_zip;
    end
  end

  always_comb begin
    rbuf_valid_d = rbuf_valid_q;
    rbuf_d       = rbuf_q;
    if (wb_ex || accept) begin
      rbuf_valid_d = 1'b0;
    end else if (hold_capture) begin
      rbuf_valid_d = 1'b1;
      rbuf_d       = data_sram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ms_valid_q   <= 1'b0;
      bnd_q        <= '0;
      zip_q        <= '0;
      rbuf_valid_q <= 1'b0;
      rbuf_q       <= '0;
    end else begin
      ms_valid_q   <= ms_valid_d;
      bnd_q        <= bnd_d;
      zip_q        <= zip_d;
      rbuf_valid_q <= rbuf_valid_d;
      rbuf_q       <= rbuf_d;
    end
  end

  assign eff_rdata = rbuf_valid_q ? rbuf_q : data_sram_rdata;

  load_align u_load_align (
    .rdata   (eff_rdata),
    .offset  (bnd_q.alu_result[1:0]),
    .ld_inst (bnd_q.ld_inst),
    .result  (ld_data)
  );

  assign ms_ex           = ms_valid_q && zip_is_ex(zip_q);
  assign ms_pc           = bnd_q.pc;
  assign ms_rf_we        = ms_valid_q && bnd_q.rf_we && !ms_ex;
  assign ms_rf_waddr     = bnd_q.rf_waddr;
  assign ms_rf_wdata     = bnd_q.res_from_mem ? ld_data : bnd_q.alu_result;
  assign ms_res_from_mem = bnd_q.res_from_mem;
  assign ms_csr_re       = bnd_q.csr_re;
  assign ms_ex_zip       = zip_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomised scoreboard bench for mem_stage.
// Stimulus pushes expected write-back records; a negedge monitor checks them.
module tb_mem_stage;

  localparam int ZW = 81;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          es_to_ms_valid = 1'b0;
  logic          ms_allowin;
  logic [31:0]   es_pc = '0;
  logic          es_rf_we = 1'b0;
  logic [4:0]    es_rf_waddr = '0;
  logic [31:0]   es_alu_result = '0;
  logic          es_res_from_mem = 1'b0;
  logic [4:0]    es_ld_inst = '0;
  logic          es_csr_re = 1'b0;
  logic [ZW-1:0] es_ex_zip = '0;
  logic [31:0]   data_sram_rdata = '0;
  logic          ws_allowin = 1'b0;
  logic          wb_ex = 1'b0;
  logic          ms_to_ws_valid;
  logic [31:0]   ms_pc;
  logic          ms_rf_we;
  logic [4:0]    ms_rf_waddr;
  logic [31:0]   ms_rf_wdata;
  logic          ms_res_from_mem;
  logic          ms_csr_re;
  logic [ZW-1:0] ms_ex_zip;
  logic          ms_ex;

  always #5 clk = ~clk;

  mem_stage #(.EX_ZIP_W(ZW), .ADDR_W(32)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .es_to_ms_valid  (es_to_ms_valid),
    .ms_allowin      (ms_allowin),
    .es_pc           (es_pc),
    .es_rf_we        (es_rf_we),
    .es_rf_waddr     (es_rf_waddr),
    .es_alu_result   (es_alu_result),
    .es_res_from_mem (es_res_from_mem),
    .es_ld_inst      (es_ld_inst),
    .es_csr_re       (es_csr_re),
    .es_ex_zip       (es_ex_zip),
    .data_sram_rdata (data_sram_rdata),
    .ws_allowin      (ws_allowin),
    .wb_ex           (wb_ex),
    .ms_to_ws_valid  (ms_to_ws_valid),
    .ms_pc           (ms_pc),
    .ms_rf_we        (ms_rf_we),
    .ms_rf_waddr     (ms_rf_waddr),
    .ms_rf_wdata     (ms_rf_wdata),
    .ms_res_from_mem (ms_res_from_mem),
    .ms_csr_re       (ms_csr_re),
    .ms_ex_zip       (ms_ex_zip),
    .ms_ex           (ms_ex)
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  waddr;
    logic        we;
    logic [31:0] wdata;
    logic        ex;
    logic        rfm;
    logic        csr;
    logic [1:0]  zlo;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  bit          mv;
  bit          fresh;
  bit          rst_chk;
  bit          mon_en;
  logic [31:0] fresh_r;
  int          n_chk;
  int          n_fail;

  function automatic logic [31:0] ref_wdata(
    input logic [4:0] t, input logic [31:0] a, input logic [31:0] r
  );
    int b, h;
    b = int'((r >> (8 * a[1:0])) & 32'hFF);
    h = int'((r >> (16 * a[1])) & 32'hFFFF);
    if (t[4]) return 32'(b >= 128 ? b - 256 : b);
    if (t[3]) return 32'(b);
    if (t[2]) return 32'(h >= 32768 ? h - 65536 : h);
    if (t[1]) return 32'(h);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_chk) begin
        chk("rst_valid", 32'(ms_to_ws_valid), 32'd0);
        chk("rst_allowin", 32'(ms_allowin), 32'd1);
        chk("rst_pc", ms_pc, 32'd0);
        chk("rst_we", 32'(ms_rf_we), 32'd0);
        chk("rst_waddr", 32'(ms_rf_waddr), 32'd0);
        chk("rst_wdata", ms_rf_wdata, 32'd0);
        chk("rst_rfm", 32'(ms_res_from_mem), 32'd0);
        chk("rst_csr", 32'(ms_csr_re), 32'd0);
        chk("rst_zip", 32'(|ms_ex_zip), 32'd0);
        chk("rst_ex", 32'(ms_ex), 32'd0);
      end else begin
        chk("valid", 32'(ms_to_ws_valid), 32'(mv));
        chk("allowin", 32'(ms_allowin), 32'(!mv || ws_allowin));
        if (mv) begin
          if (sbq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_empty: got valid bundle expected none at %0t",
                     $time);
          end else begin
            mon_e = sbq[0];
            chk("pc", ms_pc, mon_e.pc);
            chk("waddr", 32'(ms_rf_waddr), 32'(mon_e.waddr));
            chk("rf_we", 32'(ms_rf_we), 32'(mon_e.we));
            chk("wdata", ms_rf_wdata, mon_e.wdata);
            chk("ms_ex", 32'(ms_ex), 32'(mon_e.ex));
            chk("rfm", 32'(ms_res_from_mem), 32'(mon_e.rfm));
            chk("csr_re", 32'(ms_csr_re), 32'(mon_e.csr));
            chk("zip_lo", 32'(ms_ex_zip[1:0]), 32'(mon_e.zlo));
            if (ws_allowin) void'(sbq.pop_front());
          end
        end else begin
          chk("idle_we", 32'(ms_rf_we), 32'd0);
          chk("idle_ex", 32'(ms_ex), 32'd0);
        end
      end
    end
  end

  task automatic step(
    input bit v, input logic [31:0] pc, input bit we, input logic [4:0] wa,
    input logic [31:0] alu, input bit rfm, input logic [4:0] ld,
    input bit csr, input logic [1:0] zlo, input logic [31:0] r,
    input bit wsa, input bit wbx
  );
    exp_t          e;
    bit            acc;
    logic [ZW-1:0] z;
    z = {17'($urandom), $urandom, $urandom};
    z[1:0] = zlo;
    es_to_ms_valid  = v;
    es_pc           = pc;
    es_rf_we        = we;
    es_rf_waddr     = wa;
    es_alu_result   = alu;
    es_res_from_mem = rfm;
    es_ld_inst      = ld;
    es_csr_re       = csr;
    es_ex_zip       = z;
    wb_ex           = wbx;
    ws_allowin      = wbx ? 1'b0 : wsa;
    data_sram_rdata = fresh ? fresh_r : $urandom;
    acc = v && (!mv || ws_allowin) && !wbx;
    if (acc) begin
      e.pc    = pc;
      e.waddr = wa;
      e.ex    = (zlo != 2'b00);
      e.we    = we && !e.ex;
      e.wdata = rfm ? ref_wdata(ld, alu, r) : alu;
      e.rfm   = rfm;
      e.csr   = csr;
      e.zlo   = zlo;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    if (wbx) begin
      if (mv) void'(sbq.pop_front());
      mv = 1'b0;
    end else if (!mv || ws_allowin) begin
      mv = v;
    end
    fresh   = acc;
    fresh_r = r;
    rst_chk = 1'b0;
  endtask

  task automatic idle(input bit wsa, input bit wbx);
    step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, $urandom, wsa, wbx);
  endtask

  task automatic ld(input logic [31:0] pc, input logic [31:0] a,
                    input logic [4:0] t, input logic [31:0] r, input bit wsa);
    step(1, pc, 1, 5'd3, a, 1, t, 0, 2'b00, r, wsa, 0);
  endtask

  task automatic do_reset();
    resetn          = 1'b0;
    es_to_ms_valid  = 1'b0;
    wb_ex           = 1'b0;
    ws_allowin      = 1'b0;
    data_sram_rdata = $urandom;
    @(posedge clk);
    #1;
    sbq.delete();
    mv      = 1'b0;
    fresh   = 1'b0;
    rst_chk = 1'b1;
    resetn  = 1'b1;
  endtask

  logic [4:0] ld_types[6] = '{5'b10000, 5'b01000, 5'b00100,
                              5'b00010, 5'b00001, 5'b00000};

  initial begin
    do_reset();
    mon_en = 1'b1;

    ld(32'h100, 32'h1003, 5'b10000, 32'h80FF_1234, 1);
    ld(32'h104, 32'h1003, 5'b01000, 32'h80FF_1234, 1);
    ld(32'h108, 32'h2002, 5'b00100, 32'h8001_7FFF, 1);
    ld(32'h10C, 32'h2000, 5'b00010, 32'h8001_7FFF, 1);
    idle(1, 0);

    ld(32'h200, 32'h3000, 5'b00001, 32'hCAFE_F00D, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 32'hDEAD_BEEF, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 32'hDEAD_BEEF, 0, 0);
    idle(1, 0);

    step(1, 32'h300, 1, 5'd7, 32'h55, 0, 0, 0, 2'b10, 0, 1, 0);
    step(1, 32'h304, 1, 5'd8, 32'h66, 0, 0, 0, 2'b00, 0, 1, 1);
    idle(1, 0);

    ld(32'h400, 32'h4001, 5'b10000, 32'h1234_F0AA, 1);
    idle(0, 0);
    idle(0, 0);
    do_reset();
    ld(32'h404, 32'h4002, 5'b00010, 32'hABCD_0001, 1);
    idle(0, 0);
    idle(1, 0);

    step(1, 32'h500, 1, 5'd9, 32'h1234_5678, 0, 0, 0, 2'b00, 0, 1, 0);
    ld(32'h504, 32'h5000, 5'b00001, 32'h0BAD_CAFE, 1);
    idle(1, 0);

    ld(32'h600, 32'h6000, 5'b00001, 32'h7777_8888, 1);
    idle(0, 0);
    idle(0, 1);
    ld(32'h604, 32'h6003, 5'b01000, 32'h9900_0000, 0);
    idle(1, 0);

    for (int i = 0; i < 400; i++) begin
      bit          v, wsa, wbx, rfm;
      logic [1:0]  zlo;
      v   = ($urandom_range(0, 9) < 7);
      wsa = ($urandom_range(0, 9) < 7);
      wbx = ($urandom_range(0, 19) == 0);
      rfm = $urandom_range(0, 1) == 1;
      zlo = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      step(v, $urandom, $urandom_range(0, 1) == 1, 5'($urandom),
           $urandom, rfm, rfm ? ld_types[$urandom_range(0, 5)] : 5'b00000,
           $urandom_range(0, 1) == 1, zlo, $urandom, wsa, wbx);
    end
    idle(1, 0);
    idle(1, 0);
    idle(1, 0);

    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access pipeline stage directly downstream of the execute stage and upstream of write-back. It latches the execute-stage bundle and receives the synchronous data-SRAM read data one cycle after the execute stage issued the access. It aligns and extends load data, selects the register-file write value, and reports its exception status upstream so stores behind an exception are suppressed. A one-entry read-data hold buffer keeps load data intact while write-back stalls.

Parameters:
EX_ZIP_W, 81, width of the CSR/exception bundle; bit1 = syscall, bit0 = ertn
ADDR_W, 32, address/data width (fixed 32 in this core)

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
es_to_ms_valid  in  1  execute-stage bundle valid
ms_allowin  out  1  memory stage can accept a bundle
es_pc  in  32  instruction PC
es_rf_we  in  1  register write enable
es_rf_waddr  in  5  destination register
es_alu_result  in  32  ALU result, or memory address for loads/stores
es_res_from_mem  in  1  instruction is a load
es_ld_inst  in  5  load type, one-hot: [4]ld_b [3]ld_bu [2]ld_h [1]ld_hu [0]ld_w
es_csr_re  in  1  CSR read
es_ex_zip  in  EX_ZIP_W  CSR/exception bundle
data_sram_rdata  in  32  synchronous SRAM read data
ws_allowin  in  1  write-back stage can accept a bundle
wb_ex  in  1  exception/ertn commit flush from write-back
ms_to_ws_valid  out  1  bundle valid to write-back
ms_pc  out  32  registered PC
ms_rf_we  out  1  gated write enable (valid & rf_we); also the forwarding flag
ms_rf_waddr  out  5  destination register
ms_rf_wdata  out  32  load data or ALU result
ms_res_from_mem  out  1  registered load flag
ms_csr_re  out  1  registered CSR read
ms_ex_zip  out  EX_ZIP_W  registered bundle
ms_ex  out  1  ms_valid & (zip[1] | zip[0])

Behaviour:
- ms_ready_go = 1, so there is no internal stall.
- ms_allowin = !ms_valid | ws_allowin.
- ms_to_ws_valid = ms_valid.
- ms_valid update:
  - reset: 0
  - wb_ex: 0 (takes priority over accept)
  - else if ms_allowin: ms_valid <= es_to_ms_valid
- Bundle registers load on es_to_ms_valid & ms_allowin & !wb_ex. All reset to 0: pc, rf_we, waddr, alu_result, res_from_mem, ld_inst, csr_re, ex_zip.
- Outputs at reset: every output is 0 except ms_allowin, which is 1.
- Read-data hold buffer:
  - rbuf_valid is set to 1 in the first cycle ms_valid & !ws_allowin holds with a load resident. In that cycle rbuf captures data_sram_rdata.
  - rbuf_valid is cleared on any new accept, on wb_ex, and on reset.
  - Effective rdata is rbuf when rbuf_valid, else data_sram_rdata.
- Load extraction, with byte offset a = alu_result[1:0]:
  - ld_w: full word; a is ignored (no alignment fault at this stage).
  - ld_h / ld_hu: halfword selected by a[1]; sign- or zero-extended.
  - ld_b / ld_bu: byte selected by a; sign- or zero-extended.
  - ld_inst all-zero with res_from_mem = 1: word load.
- ms_rf_wdata = res_from_mem ? load_data : alu_result.
- ms_rf_we = ms_valid & rf_we & !ms_ex.
- Simultaneous wb_ex and es_to_ms_valid: the incoming bundle is dropped and ms_valid becomes 0.
- Simultaneous wb_ex and an active stall: the hold buffer is flushed.
- Back-to-back loads with continuous ws_allowin: the buffer is never set; throughput is 1 instruction per cycle.

Decomposition:
- Shared package holds:
  - load-type bit indices (LD_B, LD_BU, LD_H, LD_HU, LD_W)
  - ex_zip field positions (ZIP_SYSCALL = 1, ZIP_ERTN = 0, CSR fields)
  - EX_ZIP_W
- Sub-module load_align: purely combinational rdata/offset/ld_inst to 32-bit result. It is reused by later cache work.

Test Plan:
- ld_b at address 0x1003, rdata 0x80FF_1234: wdata 0xFFFF_FF80. ld_bu at the same address: 0x0000_0080.
- ld_h at 0x2002, rdata 0x8001_7FFF: wdata 0xFFFF_8001. ld_hu at 0x2000: 0x0000_7FFF.
- Load accepted with ws_allowin held low 3 cycles while data_sram_rdata changes to 0xDEAD_BEEF after cycle 1: wdata stays the original value and ms_allowin stays 0. Output is released when ws_allowin = 1.
- Bundle with zip[1] = 1: ms_ex = 1 and ms_rf_we = 0. Then pulse wb_ex in the same cycle as es_to_ms_valid: ms_valid = 0 next cycle.
- Resetn low mid-stall with a load buffered: next cycle ms_valid = 0, rbuf_valid = 0, ms_allowin = 1, and all outputs 0.
- ALU op (res_from_mem = 0, alu_result 0x1234_5678) back-to-back with a ld_w: one instruction per cycle; wdata 0x1234_5678, then rdata.
